// File: rtl/bcd_to_bin_converter.sv
// Converts NDIG packed BCD digits to binary on a button press, by multiply-by-10 and accumulate.
// The result is driven to the LEDs and to three active-low hex 7-segment displays.
module bcd_to_bin_converter #(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              but_1,
  input  logic [4*NDIG-1:0] data_wire,
  output logic [BIN_W-1:0]  bin_out,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [7:0]        s_led,
  output logic [6:0]        B_2seg7,
  output logic [6:0]        B_1seg7,
  output logic [6:0]        B_0seg7
);

  localparam int IW = 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ACCUM,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [4*NDIG-1:0] dig_r, dig_n;
  logic [BIN_W-1:0]  acc, acc_n, acc_next;
  logic [BIN_W-1:0]  bin_n;
  logic [IW-1:0]     idx, idx_n;
  logic              done_n, busy_n, err_n;
  logic              but_r, but_rr, push;
  logic [3:0]        cur_dig;
  logic              any_bad;
  logic [11:0]       disp;

  // Sync flops idle high, so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      but_r  <= 1'b1;
      but_rr <= 1'b1;
    end else begin
      but_r  <= but_1;
      but_rr <= but_r;
    end
  end

  assign push = but_rr & ~but_r;

  always_comb begin
    cur_dig = '0;
    any_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i))
        cur_dig = dig_r[i*4 +: 4];
      if (dig_r[i*4 +: 4] > 4'd9)
        any_bad = 1'b1;
    end
  end

  assign acc_next = (acc << 3) + (acc << 1)
                  + BIN_W'(cur_dig);

  always_comb begin
    state_n = state;
    dig_n   = dig_r;
    acc_n   = acc;
    idx_n   = idx;
    bin_n   = bin_out;
    done_n  = done;
    busy_n  = busy;
    err_n   = err;
    if (push) begin
      dig_n   = data_wire;
      acc_n   = '0;
      idx_n   = IW'(NDIG - 1);
      done_n  = 1'b0;
      err_n   = 1'b0;
      busy_n  = 1'b1;
      state_n = CHECK;
    end else begin
      unique case (state)
        CHECK: begin
          if (any_bad) begin
            bin_n   = '0;
            err_n   = 1'b1;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
          end else begin
            state_n = ACCUM;
          end
        end
        ACCUM: begin
          acc_n = acc_next;
          idx_n = idx - 1'b1;
          if (idx == '0) begin
            bin_n   = acc_next;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
          end
        end
        IDLE, DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dig_r   <= '0;
      acc     <= '0;
      idx     <= '0;
      bin_out <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      dig_r   <= dig_n;
      acc     <= acc_n;
      idx     <= idx_n;
      bin_out <= bin_n;
      done    <= done_n;
      busy    <= busy_n;
      err     <= err_n;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] p;
    unique case (h)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return ~p;
  endfunction

  assign disp    = 12'(bin_out);
  assign s_led   = disp[7:0];
  assign B_2seg7 = hex7(disp[11:8]);
  assign B_1seg7 = hex7(disp[7:4]);
  assign B_0seg7 = hex7(disp[3:0]);

endmodule
